fft_stage_sequencer: RTL
========================

# fft_stage_sequencer

Sequencer for the in-place radix-2 decimation-in-time 32-point FFT datapath. For each stage it generates butterfly read addresses, twiddle indices and the delayed write-back addresses, and it runs the stages one after another. It sits between the top-level start/done handshake and the shared butterfly unit plus sample RAM, replacing free-running enable rotation with a counted schedule.

## Interface
Parameters:
- N_LOG2, 5: log2 of the FFT size. Legal range is 2..6. N = 1<<N_LOG2.
- BF_LATENCY, 3: butterfly pipeline depth in cycles, from the read issue to the write of the same butterfly. Legal range is 1..8.

Ports:
- clk_100  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request one transform; sampled only in IDLE.
- in_valid  in  1  input sample strobe; used only when FFT_BITREV_LOAD_EN is defined.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transform completes.
- load_we  out  1  RAM write strobe during the load phase.
- load_addr  out  N_LOG2  bit-reversed load address.
- rd_en  out  1  butterfly issue strobe.
- rd_addr_a, rd_addr_b  out  N_LOG2 each  butterfly operand addresses.
- tw_addr  out  N_LOG2-1  twiddle ROM index.
- wr_en  out  1  butterfly result write strobe.
- wr_addr_a, wr_addr_b  out  N_LOG2 each  result addresses.
- stage  out  3  current stage, 0..N_LOG2-1.

## Operation
- States are IDLE, LOAD, RUN, DRAIN and FIN.
- IDLE:
  - start=1 goes to LOAD when the macro is defined, otherwise to RUN.
  - stage is cleared to 0 and the butterfly counter k is cleared to 0.
- LOAD:
  - Each cycle with in_valid=1: load_we=1, load_addr = bit-reverse(load count), then the count increments.
  - After N accepted samples, go to RUN.
- RUN: one butterfly is issued per cycle, with k running 0..N/2-1.
  - span = 1<<stage; pos = k & (span-1); grp = k >> stage.
  - rd_addr_a = (grp << (stage+1)) | pos; rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (N_LOG2-1-stage).
  - rd_en=1 on every RUN cycle. After k = N/2-1, go to DRAIN.
- Write path:
  - A BF_LATENCY-deep shift register carries {valid, addr_a, addr_b}.
  - wr_en and wr_addr_a/b are the outputs of its last stage.
  - wr_en is therefore rd_en delayed by exactly BF_LATENCY cycles.
- DRAIN:
  - Waits until the shift register is empty, i.e. the final write of the stage has been presented. No reads are issued.
  - Exit on the cycle after the final wr_en:
    - if stage < N_LOG2-1, increment stage, clear k and go to RUN;
    - otherwise go to FIN.
  - Because RUN never starts before the previous stage's writes finish, no read-after-write hazard exists.
- FIN: done=1 for one cycle, then go to IDLE.
- start is ignored while busy=1. A start that coincides with FIN does not queue.
- Address outputs are only meaningful while their strobe is high. While a strobe is low, its address outputs hold 0.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Reset is asynchronous, so it may abort mid-transform; the pipeline is flushed and no further wr_en occurs.
- Without the macro, for a start accepted at edge t:
  - stage s issues reads on cycles t+1+s·(N/2+BF_LATENCY) through t+s·(N/2+BF_LATENCY)+N/2.
  - done is high on cycle t+1+N_LOG2·(N/2+BF_LATENCY). For the defaults this is t+96.
- With the macro, the schedule above starts from the edge that accepts the N-th sample instead of t.
- The wrap of k and the increment of stage are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FFT_BITREV_LOAD_EN:
  - When defined, the LOAD state and the in_valid/load_we/load_addr logic are present.
  - When undefined, LOAD does not exist, start goes directly to RUN, in_valid is ignored, and load_we/load_addr are tied to 0. The RAM is then assumed to be preloaded in bit-reversed order by external logic.

## Test plan
- Reset, then start pulse, macro off, defaults:
  - rd_en is high for 16 cycles per stage;
  - wr_en follows rd_en by 3 cycles;
  - done pulses exactly once at t+96;
  - busy falls together with the done cycle.
- Address check across all 5 stages:
  - stage 0, k=1 gives (2,3,tw 0);
  - stage 2, k=5 gives (9,13,tw 4);
  - stage 4, k=15 gives (15,31,tw 15);
  - every address is written exactly once per stage.
- start held high for the whole transform: a single transform runs, and a new one begins only from IDLE after done.
- reset_n pulled low during stage 2:
  - outputs go to 0 immediately;
  - no wr_en follows the release of reset;
  - a fresh start completes normally.
- Macro on, in_valid gapped (1,0,1,…) for 32 samples:
  - load_addr sequence begins 0,16,8,24,4;
  - RUN starts the cycle after the 32nd sample.
- BF_LATENCY=1 and N_LOG2=3: done arrives at t+1+3·(4+1)=t+16.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Schedules an in-place radix-2 DIT FFT: optional bit-reversed load, one butterfly per cycle per stage,
// and write-back addresses delayed by BF_LATENCY. Define FFT_BITREV_LOAD_EN to add the LOAD phase.
module fft_stage_sequencer #(
    parameter int N_LOG2     = 5,
    parameter int BF_LATENCY = 3
) (
    input  logic              clk_100,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              busy,
    output logic              done,
    output logic              load_we,
    output logic [N_LOG2-1:0] load_addr,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b,
    output logic [2:0]        stage
);
    localparam int N  = 1 << N_LOG2;
    localparam int KW = N_LOG2 - 1;
    localparam int TW = N_LOG2 - 1;
    localparam logic [KW-1:0] K_LAST     = KW'((N / 2) - 1);
    localparam logic [2:0]    LAST_STAGE = 3'(N_LOG2 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
`ifdef FFT_BITREV_LOAD_EN
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FIRST = S_LOAD;
`else
    localparam logic [2:0] S_FIRST = S_RUN;
`endif

    logic [2:0]        state;
    logic [KW-1:0]     k;
    logic              pending;
    logic [N_LOG2-1:0] span;
    logic [N_LOG2-1:0] kk;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] addr_a;
    logic [TW-1:0]     tw_idx;

    logic              sr_vld [BF_LATENCY];
    logic [N_LOG2-1:0] sr_a   [BF_LATENCY];
    logic [N_LOG2-1:0] sr_b   [BF_LATENCY];

`ifdef FFT_BITREV_LOAD_EN
    logic [N_LOG2-1:0] load_cnt;
    logic [N_LOG2-1:0] load_cnt_rev;
    logic              load_take;
    logic              load_last;

    assign load_take = (state == S_LOAD) && in_valid;
    assign load_last = load_take && (load_cnt == N_LOG2'(N - 1));

    always_comb begin
        load_cnt_rev = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            load_cnt_rev[i] = load_cnt[N_LOG2-1-i];
        end
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt  <= '0;
            load_we   <= 1'b0;
            load_addr <= '0;
        end else begin
            load_we   <= load_take;
            load_addr <= load_take ? load_cnt_rev : '0;
            if (state != S_LOAD) begin
                load_cnt <= '0;
            end else if (in_valid) begin
                load_cnt <= load_cnt + N_LOG2'(1);
            end
        end
    end
`else
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
    assign load_we         = 1'b0;
    assign load_addr       = '0;
`endif

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            stage <= '0;
            k     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    stage <= '0;
                    k     <= '0;
                    if (start) begin
                        state <= S_FIRST;
                    end
                end
`ifdef FFT_BITREV_LOAD_EN
                S_LOAD: begin
                    if (load_last) begin
                        state <= S_RUN;
                    end
                end
`endif
                S_RUN: begin
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                // Leave only once the last write of this stage is on the outputs.
                S_DRAIN: begin
                    if (!pending) begin
                        if (stage == LAST_STAGE) begin
                            state <= S_FIN;
                        end else begin
                            stage <= stage + 3'd1;
                            k     <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                S_FIN: begin
                    stage <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_FIN);
    assign rd_en = (state == S_RUN);

    always_comb begin
        span   = N_LOG2'(1) << stage;
        kk     = N_LOG2'(k);
        pos    = kk & (span - N_LOG2'(1));
        grp    = kk >> stage;
        addr_a = (grp << (stage + 3'd1)) | pos;
        tw_idx = TW'(pos << (LAST_STAGE - stage));
    end

    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? (addr_a + span) : '0;
    assign tw_addr   = rd_en ? tw_idx : '0;

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < BF_LATENCY - 1; i++) begin
            pending = pending | sr_vld[i];
        end
    end

    // Addresses enter as zero when no read is issued, so the write side holds 0 between strobes.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                sr_vld[i] <= 1'b0;
                sr_a[i]   <= '0;
                sr_b[i]   <= '0;
            end
        end else begin
            sr_vld[0] <= rd_en;
            sr_a[0]   <= rd_addr_a;
            sr_b[0]   <= rd_addr_b;
            for (int i = 1; i < BF_LATENCY; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_a[i]   <= sr_a[i-1];
                sr_b[i]   <= sr_b[i-1];
            end
        end
    end

    assign wr_en     = sr_vld[BF_LATENCY-1];
    assign wr_addr_a = sr_a[BF_LATENCY-1];
    assign wr_addr_b = sr_b[BF_LATENCY-1];

endmodule
